wb_hb_initiator: RTL and testbench

WB_HB_INITIATOR -- requirements
Module: wb_hb_initiator

---
 rtl/hb_pkg.sv | 20 ++
 rtl/hb_phase_timer.sv | 27 ++
 rtl/wb_hb_initiator.sv | 155 +++++++++++++++
 tb/tb_wb_hb_initiator.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hb_pkg.sv
// Shared definitions for the Wishbone-to-host-bus initiator:
// FSM encoding, default phase lengths and the phase-counter width.
package hb_pkg;

  localparam int PH_W = 4;

  localparam int SETUP_CYC_DEF    = 1;
  localparam int STROBE_CYC_DEF   = 2;
  localparam int HOLD_CYC_DEF     = 1;
  localparam int WAIT_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } hb_state_t;

endpackage

// File: rtl/hb_phase_timer.sv
// Loadable down-counter shared by the setup, strobe and hold phases.
// A phase loaded with N-1 reports expiry during its N-th cycle.
module hb_phase_timer
  import hb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PH_W-1:0] val,
  output logic            expired
);

  logic [PH_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/wb_hb_initiator.sv
// Wishbone classic slave that runs one asynchronous-style host bus
// cycle (setup / strobe / hold) per accepted request.
module wb_hb_initiator
  import hb_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int SETUP_CYC    = SETUP_CYC_DEF,
  parameter int STROBE_CYC   = STROBE_CYC_DEF,
  parameter int HOLD_CYC     = HOLD_CYC_DEF,
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cycle,
  input  logic                  wb_strobe,
  input  logic                  wb_write,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_wrData,
  output logic [DATA_WIDTH-1:0] wb_rdData,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic                  hb_cs,
  output logic                  hb_oe,
  output logic                  hb_we,
  output logic [ADDR_WIDTH-1:0] hb_addr,
  inout  wire  [DATA_WIDTH-1:0] hb_data,
  input  logic                  hb_wait
);

  localparam logic [PH_W-1:0] SETUP_LD  = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] STROBE_LD = PH_W'(STROBE_CYC - 1);
  localparam logic [PH_W-1:0] HOLD_LD   = PH_W'(HOLD_CYC - 1);
  localparam logic [7:0]      WAIT_MAX  = 8'(WAIT_TIMEOUT);

  hb_state_t state, state_n;

  logic                  tm_load;
  logic [PH_W-1:0]       tm_val;
  logic                  tm_exp;
  logic                  accept;
  logic                  leave_ok;
  logic                  tmo_set;
  logic                  wait_inc;
  logic [7:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdat_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  we_q;
  logic                  abort_q;
  logic                  tmo_q;
  logic                  active;
  logic                  done_ok;

  hb_phase_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tm_load),
    .val     (tm_val),
    .expired (tm_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tm_load  = 1'b0;
    tm_val   = '0;
    accept   = 1'b0;
    leave_ok = 1'b0;
    tmo_set  = 1'b0;
    wait_inc = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (wb_cycle && wb_strobe) begin
          accept  = 1'b1;
          state_n = S_SETUP;
          tm_load = 1'b1;
          tm_val  = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (tm_exp) begin
          state_n = S_STROBE;
          tm_load = 1'b1;
          tm_val  = STROBE_LD;
        end
      end
      S_STROBE: begin
        if (tm_exp) begin
          if (!hb_wait) begin
            state_n  = S_HOLD;
            tm_load  = 1'b1;
            tm_val   = HOLD_LD;
            leave_ok = 1'b1;
          end else if (wait_cnt == WAIT_MAX) begin
            state_n = S_HOLD;
            tm_load = 1'b1;
            tm_val  = HOLD_LD;
            tmo_set = 1'b1;
          end else begin
            wait_inc = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (tm_exp) state_n = S_DONE;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      wdat_q   <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      abort_q  <= 1'b0;
      tmo_q    <= 1'b0;
      wait_cnt <= '0;
    end else if (accept) begin
      addr_q   <= wb_addr;
      wdat_q   <= wb_wrData;
      we_q     <= wb_write;
      abort_q  <= 1'b0;
      tmo_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      // A dropped cycle is remembered so the response is swallowed.
      if (state != S_IDLE && !wb_cycle) abort_q <= 1'b1;
      if (wait_inc) wait_cnt <= wait_cnt + 8'd1;
      if (tmo_set) tmo_q <= 1'b1;
      if (leave_ok && !we_q) rd_q <= hb_data;
    end
  end

  assign active  = (state == S_SETUP) || (state == S_STROBE)
                || (state == S_HOLD);
  assign hb_cs   = ~active;
  assign hb_oe   = ~((state == S_STROBE) && !we_q);
  assign hb_we   = ~((state == S_STROBE) && we_q);
  assign hb_addr = addr_q;
  assign hb_data = (active && we_q) ? wdat_q : 'z;

  assign done_ok   = (state == S_DONE) && wb_cycle && !abort_q;
  assign wb_ack    = done_ok && !tmo_q;
  assign wb_err    = done_ok && tmo_q;
  assign wb_rdData = rd_q;

endmodule

// File: tb/tb_wb_hb_initiator.sv
// Directed bench for wb_hb_initiator: stimulus pushes expected
// responses, a negedge monitor pops and compares them.
module tb_wb_hb_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cycle, wb_strobe, wb_write;
  logic [15:0] wb_addr, wb_wrData;
  logic [15:0] wb_rdData;
  logic        wb_ack, wb_err;
  logic        hb_cs, hb_oe, hb_we;
  logic [15:0] hb_addr;
  wire  [15:0] hb_data;
  logic        hb_wait;
  logic [15:0] tgt_val;

  typedef struct {
    bit          err;
    logic [15:0] rd;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] rd_model;

  wb_hb_initiator #(.WAIT_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_cycle  (wb_cycle),
    .wb_strobe (wb_strobe),
    .wb_write  (wb_write),
    .wb_addr   (wb_addr),
    .wb_wrData (wb_wrData),
    .wb_rdData (wb_rdData),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .hb_cs     (hb_cs),
    .hb_oe     (hb_oe),
    .hb_we     (hb_we),
    .hb_addr   (hb_addr),
    .hb_data   (hb_data),
    .hb_wait   (hb_wait)
  );

  // Target drives read data while output enable is low; idle bus floats high.
  assign hb_data = hb_oe ? 'z : tgt_val;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (hb_data[g]);
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", n, a, e, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && (wb_ack || wb_err)) begin
      chk("ack_err_excl", {31'd0, wb_ack && wb_err}, 32'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: ack=%b err=%b cyc %0d",
                 wb_ack, wb_err, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_err", {31'd0, wb_err}, {31'd0, e.err});
        chk("resp_cyc", cyc, e.cyc);
        chk("resp_rd", {16'd0, wb_rdData}, {16'd0, e.rd});
      end
    end
  end

  task automatic txn(input bit wr, input logic [15:0] a,
                     input logic [15:0] d, input int wst,
                     input int wlen, input bit drop, input bit tmo);
    int c0, sl, lat;
    int cs_lo, oe_lo, we_lo, d_ok, a_ok;
    exp_t e;
    c0 = cyc;
    sl = tmo ? 2 + 4 : 2 + wlen;
    lat = 1 + sl + 1 + 1;
    cs_lo = 0; oe_lo = 0; we_lo = 0; d_ok = 0; a_ok = 0;
    wb_cycle = 1'b1; wb_strobe = 1'b1;
    wb_write = wr; wb_addr = a; wb_wrData = d;
    if (!wr && !tmo) rd_model = tgt_val;
    if (!drop) begin
      e.err = tmo;
      e.rd  = rd_model;
      e.cyc = c0 + lat;
      q.push_back(e);
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      hb_wait = (k >= wst) && (k < wst + wlen);
      cs_lo += int'(!hb_cs);
      oe_lo += int'(!hb_oe);
      we_lo += int'(!hb_we);
      if (k < lat) begin
        if (hb_addr === a) a_ok++;
        if (wr && hb_data === d) d_ok++;
      end
      if (drop && k == 1) begin
        wb_cycle = 1'b0; wb_strobe = 1'b0;
      end
      if (k == lat) begin
        #1;
        wb_cycle = 1'b0; wb_strobe = 1'b0;
      end
    end
    hb_wait = 1'b0;
    chk("cs_low_cycles", cs_lo, lat - 1);
    chk("oe_low_cycles", oe_lo, wr ? 0 : sl);
    chk("we_low_cycles", we_lo, wr ? sl : 0);
    chk("addr_driven", a_ok, lat - 1);
    chk("wdata_driven", d_ok, wr ? lat - 1 : 0);
    @(negedge clk);
    chk("cs_idle", {31'd0, hb_cs}, 32'd1);
    chk("data_z_idle", {16'd0, hb_data}, 32'hFFFF);
    chk("addr_hold", {16'd0, hb_addr}, {16'd0, a});
  endtask

  initial begin
    rst = 1'b0;
    wb_cycle = 1'b0; wb_strobe = 1'b0; wb_write = 1'b0;
    wb_addr = '0; wb_wrData = '0; hb_wait = 1'b0;
    tgt_val = '0; rd_model = '0;
    repeat (2) @(negedge clk);
    chk("rst_cs", {31'd0, hb_cs}, 32'd1);
    chk("rst_oe_we", {30'd0, hb_oe, hb_we}, 32'd3);
    chk("rst_addr", {16'd0, hb_addr}, 32'd0);
    chk("rst_rd", {16'd0, wb_rdData}, 32'd0);
    chk("rst_ack_err", {30'd0, wb_ack, wb_err}, 32'd0);
    chk("rst_data_z", {16'd0, hb_data}, 32'hFFFF);
    rst = 1'b1;

    txn(1'b1, 16'h1234, 16'hBEEF, 0, 0, 1'b0, 1'b0);
    tgt_val = 16'h5A5A;
    txn(1'b0, 16'h0042, 16'h0000, 0, 0, 1'b0, 1'b0);
    tgt_val = 16'h1357;
    txn(1'b0, 16'h0100, 16'h0000, 3, 3, 1'b0, 1'b0);
    tgt_val = 16'hDEAD;
    txn(1'b0, 16'h0180, 16'h0000, 3, 20, 1'b0, 1'b1);
    txn(1'b1, 16'h0200, 16'h0F0F, 0, 0, 1'b1, 1'b0);
    txn(1'b1, 16'h0300, 16'hA5C3, 0, 0, 1'b0, 1'b0);

    wb_cycle = 1'b1; wb_strobe = 1'b1; wb_write = 1'b1;
    wb_addr = 16'h0500; wb_wrData = 16'h7777;
    repeat (2) @(negedge clk);
    chk("pre_rst_we", {31'd0, hb_we}, 32'd0);
    rst = 1'b0;
    #1;
    chk("arst_cs", {31'd0, hb_cs}, 32'd1);
    chk("arst_oe_we", {30'd0, hb_oe, hb_we}, 32'd3);
    chk("arst_data_z", {16'd0, hb_data}, 32'hFFFF);
    chk("arst_ack_err", {30'd0, wb_ack, wb_err}, 32'd0);
    chk("arst_addr", {16'd0, hb_addr}, 32'd0);
    rd_model = '0;
    wb_cycle = 1'b0; wb_strobe = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tgt_val = 16'h2468;
    txn(1'b0, 16'h0400, 16'h0000, 0, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("resp_queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
